// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word on a valid/ready handshake
// and emits it LSB first, one bit per enabled clock. Back-to-back words stream without gaps.
module piso_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             last_bit;
    logic             accept;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;

        last_bit   = (state_q == StShift) && (cnt_q == LastCnt) && en;
        // Ready is masked by rst so nothing is offered while the block is held in reset.
        load_ready = rst && ((state_q == StIdle) || last_bit);
        accept     = load_valid && load_ready;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (en) begin
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_bit) begin
                        frame_done_d = 1'b1;
                        cnt_d        = '0;
                        if (accept) begin
                            shreg_d = data_in;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        serial_valid = (state_q == StShift);
        busy         = (state_q == StShift);
        serial_out   = (state_q == StShift) && shreg_q[0];
        frame_done   = frame_done_q;
    end

endmodule
